// File: rtl/inst_axi_fetch_master_if.sv
// AXI-Lite read channel (AR + R) between the fetch master and the instruction ROM.
// Pure wiring; handshake timing is owned by the master and the slave.
interface inst_axi_fetch_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              rready;

  modport master (output araddr, arvalid, rready, input arready, rdata, rvalid);
  modport slave  (input araddr, arvalid, rready, output arready, rdata, rvalid);
endinterface

// File: rtl/inst_axi_fetch_master.sv
// Fetch-request to single AXI-Lite read; if_valid 4 cycles after if_req with a 1-cycle slave.
// Stalls the pipeline while a read is outstanding; flushed reads are drained, never dropped.
module inst_axi_fetch_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_req,
  input  logic [ADDR_W-1:0]          if_addr,
  input  logic                       flush,
  output logic                       if_stall,
  output logic [DATA_W-1:0]          if_inst,
  output logic                       if_valid,
  output logic                       if_err,
  inst_axi_fetch_master_if.master    axi
);

  typedef enum logic [1:0] {IDLE, AR, R, DISCARD} state_t;

  state_t            state, state_n;
  logic              flush_pend, flush_pend_n;
  logic [ADDR_W-1:0] araddr_n;
  logic              arvalid_n, rready_n;
  logic [DATA_W-1:0] if_inst_n;
  logic              if_valid_n, if_err_n;
  logic              launch;

  // The if_valid/if_err cycle blocks a relaunch, giving the mandatory idle gap.
  assign launch   = if_req & ~flush & ~if_valid & ~if_err;
  assign if_stall = (state != IDLE) | launch;

  always_comb begin
    state_n      = state;
    flush_pend_n = flush_pend;
    araddr_n     = axi.araddr;
    arvalid_n    = axi.arvalid;
    rready_n     = axi.rready;
    if_inst_n    = if_inst;
    if_valid_n   = 1'b0;
    if_err_n     = 1'b0;
    case (state)
      IDLE: begin
        if (launch) begin
          if (if_addr[1:0] == 2'b00) begin
            araddr_n  = if_addr;
            arvalid_n = 1'b1;
            state_n   = AR;
          end else begin
            if_err_n = 1'b1;
          end
        end
      end
      AR: begin
        // arvalid must stay up once raised; a flush only marks the response for draining.
        if (flush) flush_pend_n = 1'b1;
        if (axi.arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = (flush_pend | flush) ? DISCARD : R;
        end
      end
      R: begin
        if (axi.rvalid) begin
          rready_n = 1'b0;
          state_n  = IDLE;
          if (!flush) begin
            if_inst_n  = axi.rdata;
            if_valid_n = 1'b1;
          end
        end else if (flush) begin
          flush_pend_n = 1'b1;
          state_n      = DISCARD;
        end
      end
      DISCARD: begin
        if (axi.rvalid) begin
          rready_n     = 1'b0;
          flush_pend_n = 1'b0;
          state_n      = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      flush_pend  <= 1'b0;
      axi.araddr  <= '0;
      axi.arvalid <= 1'b0;
      axi.rready  <= 1'b0;
      if_inst     <= '0;
      if_valid    <= 1'b0;
      if_err      <= 1'b0;
    end else begin
      state       <= state_n;
      flush_pend  <= flush_pend_n;
      axi.araddr  <= araddr_n;
      axi.arvalid <= arvalid_n;
      axi.rready  <= rready_n;
      if_inst     <= if_inst_n;
      if_valid    <= if_valid_n;
      if_err      <= if_err_n;
    end
  end

endmodule

// File: tb/tb_inst_axi_fetch_master.sv
// Bench for inst_axi_fetch_master: ROM slave model with programmable AR/R delays,
// protocol monitor and an expected-result queue popped on every if_valid/if_err.
module tb_inst_axi_fetch_master;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_stall, if_valid, if_err;
  logic [31:0] if_inst;

  inst_axi_fetch_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  inst_axi_fetch_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .flush(flush),
    .if_stall(if_stall), .if_inst(if_inst), .if_valid(if_valid), .if_err(if_err),
    .axi(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic [31:0] inst;
  } exp_t;
  exp_t exp_q[$];

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h00: rom = 32'h3c011000;
      32'h04: rom = 32'h34030002;
      32'h08: rom = 32'hac230040;
      32'h14: rom = 32'h34020032;
      32'h4c: rom = 32'h08000003;
      default: rom = {a[15:0], 16'hbeef};
    endcase
  endfunction

  // ROM slave: arready after ar_delay arvalid cycles, rvalid r_delay cycles after the AR handshake.
  int          ar_delay = 1;
  int          r_delay  = 0;
  int          ar_cnt, r_cnt, ar_count;
  logic        r_busy, r_fire, ar_fire;
  logic [31:0] r_addr, last_ar;

  initial begin
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'hdeaddead;
    r_busy = 1'b0; r_fire = 1'b0; ar_fire = 1'b0;
    ar_cnt = 0; r_cnt = 0; ar_count = 0; r_addr = 32'h0; last_ar = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.arready = 1'b0; bus.rvalid = 1'b0;
        r_busy = 1'b0; r_fire = 1'b0; ar_fire = 1'b0; ar_cnt = 0; r_cnt = 0;
      end else begin
        if (r_fire) begin
          bus.rvalid = 1'b0; bus.rdata = 32'hdeaddead; r_busy = 1'b0; r_fire = 1'b0;
        end
        if (ar_fire) begin
          bus.arready = 1'b0; ar_fire = 1'b0; r_busy = 1'b1; r_cnt = 0;
        end
        if (r_busy) begin
          if (r_cnt >= r_delay) begin
            bus.rvalid = 1'b1; bus.rdata = rom(r_addr);
          end else begin
            r_cnt++;
          end
          if (bus.rvalid && bus.rready) r_fire = 1'b1;
        end
        if (!r_busy && !ar_fire && bus.arvalid) begin
          if (ar_cnt >= ar_delay) begin
            bus.arready = 1'b1; ar_fire = 1'b1; r_addr = bus.araddr; last_ar = bus.araddr;
            ar_count++; ar_cnt = 0;
          end else begin
            ar_cnt++;
          end
        end
      end
    end
  end

  // Protocol monitor and scoreboard, sampled mid-cycle after all drivers have settled.
  logic        p_arv = 1'b0, p_ard = 1'b0, p_rst = 1'b1;
  logic [31:0] p_addr = 32'h0;
  int          overlap = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!p_rst && p_arv && !p_ard)
        check_vec("ar_hold", 64'({bus.arvalid, bus.araddr}), 64'({1'b1, p_addr}));
      if (bus.arvalid) check_vec("ar_align", 64'(bus.araddr[1:0]), 64'd0);
      if (bus.arvalid && bus.rready) overlap++;
      if (if_valid || if_err) begin
        if (exp_q.size() == 0) begin
          check_vec("sb_unexpected", 64'({if_valid, if_err}), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_vec("sb_kind", 64'({if_valid, if_err}), 64'({~e.err, e.err}));
          if (!e.err) check_vec("sb_inst", 64'(if_inst), 64'(e.inst));
        end
      end
      p_arv = bus.arvalid; p_ard = bus.arready; p_addr = bus.araddr; p_rst = rst;
    end
  end

  task automatic wait_done(output logic seen_err, output logic ok);
    ok = 1'b0; seen_err = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (if_valid || if_err) begin
        ok = 1'b1; seen_err = if_err;
      end
    end
    check_vec("done_timeout", 64'(ok), 64'd1);
  endtask

  task automatic fetch(input logic [31:0] a, input logic exp_err, input logic [31:0] exp_inst);
    logic e, ok;
    exp_t x;
    @(negedge clk);
    if_req = 1'b1; if_addr = a;
    x.err = exp_err; x.inst = exp_inst;
    exp_q.push_back(x);
    wait_done(e, ok);
    if_req = 1'b0;
    if (ok) check_vec("fetch_kind", 64'(e), 64'(exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   a0, stall_low;
    logic e, ok, found;
    exp_t x;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_vec("rst_ctrl", 64'({if_stall, if_valid, if_err, bus.arvalid, bus.rready}), 64'd0);
    check_vec("rst_araddr", 64'(bus.araddr), 64'd0);
    check_vec("rst_inst", 64'(if_inst), 64'd0);
    rst = 1'b0;

    // Latency of a single fetch of PC 0
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0;
    x.err = 1'b0; x.inst = 32'h3c011000; exp_q.push_back(x);
    for (int c = 0; c <= 4; c++) begin
      #1;
      check_vec("t1_stall", 64'(if_stall), 64'(c < 4));
      check_vec("t1_arvalid", 64'(bus.arvalid), 64'(c == 1 || c == 2));
      check_vec("t1_valid", 64'(if_valid), 64'(c == 4));
      if (c == 1) check_vec("t1_araddr", 64'(bus.araddr), 64'd0);
      if (c == 3) check_vec("t1_rready", 64'(bus.rready), 64'd1);
      if (c == 4) if_req = 1'b0;
      @(negedge clk);
    end

    // Back-to-back fetches with a slow arready
    ar_delay = 3; r_delay = 1; a0 = ar_count;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h4;
    x.err = 1'b0; x.inst = 32'h34030002; exp_q.push_back(x);
    wait_done(e, ok);
    check_vec("t2_stall_valid", 64'(if_stall), 64'd0);
    if_addr = 32'h8;
    x.err = 1'b0; x.inst = 32'hac230040; exp_q.push_back(x);
    @(negedge clk);
    #1;
    check_vec("t2_launch", 64'({bus.arvalid, if_stall}), 64'd1);
    wait_done(e, ok);
    if_req = 1'b0;
    check_vec("t2_ar_count", 64'(ar_count - a0), 64'd2);
    repeat (2) @(negedge clk);

    // Flush while AR is stalled; response drained, then the post-flush PC fetched
    ar_delay = 5; r_delay = 1; a0 = ar_count; stall_low = 0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h40;
    @(negedge clk);
    #1;
    check_vec("t3_ar_up", 64'({bus.arvalid, bus.arready}), 64'b10);
    flush = 1'b1; if_addr = 32'h4c;
    @(negedge clk);
    flush = 1'b0;
    x.err = 1'b0; x.inst = 32'h08000003; exp_q.push_back(x);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      #1;
      if (if_valid) ok = 1'b1;
      else if (!if_stall) stall_low++;
      if (!ok) @(negedge clk);
    end
    if_req = 1'b0;
    check_vec("t3_done", 64'(ok), 64'd1);
    check_vec("t3_stall_low", 64'(stall_low), 64'd0);
    check_vec("t3_ar_count", 64'(ar_count - a0), 64'd2);
    check_vec("t3_last_ar", 64'(last_ar), 64'h4c);
    repeat (2) @(negedge clk);

    // Flush coincident with rvalid in R
    ar_delay = 1; r_delay = 2; found = 1'b0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      #1;
      if (bus.rvalid && bus.rready) begin
        found = 1'b1; flush = 1'b1; if_req = 1'b0;
      end
    end
    check_vec("t4_found", 64'(found), 64'd1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check_vec("t4_idle", 64'({if_stall, if_valid, bus.rready, bus.arvalid}), 64'd0);
    repeat (3) @(negedge clk);

    // Misaligned fetch
    a0 = ar_count;
    fetch(32'h6, 1'b1, 32'h0);
    @(negedge clk);
    #1;
    check_vec("t5_pulse", 64'({if_err, if_valid, bus.arvalid}), 64'd0);
    repeat (3) @(negedge clk);
    check_vec("t5_ar_count", 64'(ar_count - a0), 64'd0);

    // Reset while waiting in R
    ar_delay = 1; r_delay = 4; found = 1'b0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h30;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      #1;
      if (bus.rready && !bus.rvalid) found = 1'b1;
    end
    check_vec("t6_in_r", 64'(found), 64'd1);
    rst = 1'b1; if_req = 1'b0;
    @(negedge clk);
    #1;
    check_vec("t6_rst_ctrl", 64'({if_valid, if_err, bus.arvalid, bus.rready, if_stall}), 64'd0);
    check_vec("t6_rst_data", 64'({bus.araddr, if_inst}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ar_delay = 1; r_delay = 0;
    fetch(32'h14, 1'b0, 32'h34020032);
    repeat (4) @(negedge clk);

    check_vec("ar_r_overlap", 64'(overlap), 64'd0);
    check_vec("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/inst_axi_fetch_master.md
Name: inst_axi_fetch_master

Overview:
- AXI-Lite read-channel initiator between the CPU instruction-fetch stage and the instruction ROM's read port.
- Turns a fetch request (PC) into one AR/R transaction, returns the instruction word to the pipeline, and stalls the pipeline while the transaction is outstanding.
- Handles pipeline flushes mid-transaction without violating AXI handshake rules.

Parameters:
- ADDR_W, 32, width of fetch address and araddr (matches InstAddrBus).
- DATA_W, 32, width of instruction word and rdata (matches InstBus).

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, level; held by CPU until if_valid
- if_addr  in  ADDR_W  fetch PC; stable while if_req and if_stall
- flush  in  1  pipeline flush (branch/exception); kills current fetch
- if_stall  out  1  combinational; pipeline must hold PC/IF stage
- if_inst  out  DATA_W  fetched instruction, valid when if_valid
- if_valid  out  1  one-cycle pulse: if_inst valid
- if_err  out  1  one-cycle pulse: misaligned fetch (if_addr[1:0] != 0)
- araddr  out  ADDR_W  AXI read address, low 2 bits always 0
- arvalid  out  1  AXI address valid
- arready  in  1  AXI address ready
- rdata  in  DATA_W  AXI read data
- rvalid  in  1  AXI data valid
- rready  out  1  AXI data ready

Behaviour:
- Reset: state=IDLE; arvalid=0, rready=0, araddr=0, if_inst=0, if_valid=0, if_err=0.
- Reset mid-transaction: same values next cycle; nothing in flight is delivered.
- States: IDLE, AR, R, DISCARD (2-bit register). All outputs except if_stall are registered.
- IDLE:
  - launch = if_req & ~flush & ~if_valid & ~if_err.
  - If launch and if_addr[1:0]==0: araddr<=if_addr, arvalid<=1, go to AR.
  - If launch and misaligned: if_err<=1 for one cycle, no bus activity, stay in IDLE.
  - One idle cycle between consecutive fetches (the if_valid/if_err cycle) is required.
- AR:
  - Hold arvalid=1 and a stable araddr until arready.
  - arvalid never depends combinationally on arready.
  - On arvalid & arready: arvalid<=0, rready<=1, go to R (or DISCARD if a flush is pending).
  - A flush in AR sets flush_pend=1. arvalid is NOT dropped.
- R:
  - rready=1.
  - On rvalid with no flush this cycle: if_inst<=rdata, if_valid<=1, rready<=0, go to IDLE.
  - rvalid and flush in the same cycle: data dropped, rready<=0, go to IDLE, no if_valid.
  - Flush without rvalid: go to DISCARD.
- DISCARD:
  - rready=1.
  - On rvalid: drop data, rready<=0, clear flush_pend, go to IDLE.
  - Further flushes are ignored.
- if_valid and if_err are cleared the cycle after they assert.
- if_stall = (state != IDLE) | (if_req & ~flush & ~if_valid & ~if_err).
  - In the if_valid cycle if_stall=0, so the pipeline advances.
  - Stall stays high through DISCARD; the post-flush PC is fetched only after the bus is quiet.
- At most one outstanding transaction. The AR handshake is never issued while R or DISCARD is active.
- Latency against a slave that raises arready 1 cycle after arvalid and rvalid 1 cycle after the AR handshake:
  - if_req seen at cycle 0, arvalid at 1, AR handshake at 2, R handshake at 3, if_valid at 4.
- if_addr changes while stalled are ignored; the latched araddr is used.

Test Plan:
- Reset, then if_req=1 with if_addr=0x00000000 against the instruction ROM model -> arvalid rises the next cycle, araddr=0x0, if_valid pulses once with if_inst=0x3c011000 at cycle 4, if_stall=1 for cycles 0-3.
- Back-to-back fetches 0x4 then 0x8 -> if_inst=0x34030002 then 0xac230040. Exactly one AR per fetch, one idle cycle between them, araddr stable while arvalid=1 and arready=0.
- Flush asserted while in AR with arready held low for 5 cycles -> arvalid stays high until arready. Response is consumed in DISCARD, no if_valid. A new fetch of 0x4C is issued only after rvalid/rready, returning 0x08000003.
- Flush coincident with rvalid in R -> no if_valid, state returns to IDLE the next cycle, if_stall=0 if if_req=0.
- if_addr=0x00000006 -> if_err pulses one cycle, arvalid never rises, if_valid stays 0.
- rst asserted while in R (rvalid not yet high) -> next cycle all outputs at reset values. A subsequent fetch of 0x14 returns 0x34020032 correctly.
